// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges redirect and stall sources into the
// hold command for pc_reg/if_id/id_ex, with flush sequencing, debug halt and a stall counter.
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             ex_hold_i,
  input  logic             clint_hold_i,
  input  logic             rib_hold_i,
  input  logic             jtag_halt_i,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

  // Hold_If (2) is part of the bus encoding but never produced here.
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [2:0]       hold;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN, HALT: begin
        if (jump_flag_i) begin
          if (MULTI_FLUSH) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == RUN && jtag_halt_i) begin
          state_d = HALT;
        end else if (state_q == HALT && !jtag_halt_i) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // A redirect during a flush restarts the window: latest redirect wins.
        if (jump_flag_i) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q == 4'd1) begin
          state_d     = RUN;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    hold = HOLD_NONE;
    if (state_q == FLUSH || jump_flag_i || ex_hold_i || clint_hold_i) begin
      hold = HOLD_ID;
    end else if (rib_hold_i || state_q == HALT) begin
      hold = HOLD_PC;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (hold != HOLD_NONE && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Combinational outputs are gated so the stage registers see no command while in reset.
  assign hold_flag_o = rst ? hold : HOLD_NONE;
  assign jump_flag_o = rst & jump_flag_i;
  assign jump_addr_o = jump_flag_o ? jump_addr_i : 32'd0;
  assign halted_o    = (state_q == HALT);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: four instances share stimulus so each
// parameter point (FLUSH_CYCLES 1/2/3, CNT_W 4) is checked against hand values.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        ex_hold_i = 1'b0;
  logic        clint_hold_i = 1'b0;
  logic        rib_hold_i = 1'b0;
  logic        jtag_halt_i = 1'b0;

  logic [2:0]  hold2, hold3, hold1, holds;
  logic        jf2, jf3, jf1, jfs;
  logic [31:0] ja2, ja3, ja1, jas;
  logic        hl2, hl3, hl1, hls;
  logic [31:0] sc2, sc3, sc1;
  logic [3:0]  scs;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .clint_hold_i(clint_hold_i), .rib_hold_i(rib_hold_i),
    .jtag_halt_i(jtag_halt_i), .hold_flag_o(hold2), .jump_flag_o(jf2),
    .jump_addr_o(ja2), .halted_o(hl2), .stall_cnt_o(sc2));

  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .clint_hold_i(clint_hold_i), .rib_hold_i(rib_hold_i),
    .jtag_halt_i(jtag_halt_i), .hold_flag_o(hold3), .jump_flag_o(jf3),
    .jump_addr_o(ja3), .halted_o(hl3), .stall_cnt_o(sc3));

  pipe_hold_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .clint_hold_i(clint_hold_i), .rib_hold_i(rib_hold_i),
    .jtag_halt_i(jtag_halt_i), .hold_flag_o(hold1), .jump_flag_o(jf1),
    .jump_addr_o(ja1), .halted_o(hl1), .stall_cnt_o(sc1));

  pipe_hold_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .clint_hold_i(clint_hold_i), .rib_hold_i(rib_hold_i),
    .jtag_halt_i(jtag_halt_i), .hold_flag_o(holds), .jump_flag_o(jfs),
    .jump_addr_o(jas), .halted_o(hls), .stall_cnt_o(scs));

  // Advance into the next cycle window; inputs are driven 1 after the edge and
  // outputs sampled 1 later, well away from the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump_flag_i = 0; jump_addr_i = 0; ex_hold_i = 0;
    clint_hold_i = 0; rib_hold_i = 0; jtag_halt_i = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      jump_flag_i = i[0]; jump_addr_i = 32'hdead_0000 + 32'(i);
      ex_hold_i = i[1]; clint_hold_i = ~i[0]; rib_hold_i = 1'b1; jtag_halt_i = 1'b1;
      #3;
      compared++;
      if ({hold2, jf2, ja2, hl2, sc2} !== 69'd0) begin
        mismatched++;
        $display("FAIL reset_outputs[%0d]: hold=%0d jf=%0b ja=%h halted=%0b cnt=%0d required all 0",
                 i, hold2, jf2, ja2, hl2, sc2);
      end
    end
    clear_inputs();
    next_cycle();
    rst = 1;
    next_cycle();
    compared++;
    if (hold2 !== 3'd0 || sc2 !== 32'd0 || hl2 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: hold=%0d cnt=%0d halted=%0b required 0/0/0", hold2, sc2, hl2);
    end
  endtask

  task automatic test_jump_flush();
    do_reset();
    jump_flag_i = 1; jump_addr_i = 32'h0000_0100;
    #1;
    compared++;
    if (hold2 !== 3'd3 || jf2 !== 1'b1 || ja2 !== 32'h100) begin
      mismatched++;
      $display("FAIL flush_c0: hold=%0d jf=%0b ja=%h required 3/1/100", hold2, jf2, ja2);
    end
    compared++;
    if (hold1 !== 3'd3 || jf1 !== 1'b1) begin
      mismatched++;
      $display("FAIL flush1_c0: hold=%0d jf=%0b required 3/1", hold1, jf1);
    end
    next_cycle();
    jump_flag_i = 0; jump_addr_i = 32'h0000_0100;
    #1;
    compared++;
    if (hold2 !== 3'd3 || jf2 !== 1'b0 || ja2 !== 32'd0) begin
      mismatched++;
      $display("FAIL flush_c1: hold=%0d jf=%0b ja=%h required 3/0/0", hold2, jf2, ja2);
    end
    compared++;
    if (hold1 !== 3'd0) begin
      mismatched++;
      $display("FAIL flush1_c1: hold=%0d required 0", hold1);
    end
    next_cycle();
    #1;
    compared++;
    if (hold2 !== 3'd0 || sc2 !== 32'd2) begin
      mismatched++;
      $display("FAIL flush_c2: hold=%0d cnt=%0d required 0/2", hold2, sc2);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_hold [5] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      jump_flag_i = (c < 2);
      jump_addr_i = (c == 0) ? 32'h100 : (c == 1) ? 32'h200 : 32'h0;
      #1;
      compared++;
      if (hold3 !== exp_hold[c]) begin
        mismatched++;
        $display("FAIL b2b_hold_c%0d: got %0d required %0d", c, hold3, exp_hold[c]);
      end
      if (c == 1) begin
        compared++;
        if (ja3 !== 32'h200 || jf3 !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_addr_c1: jf=%0b ja=%h required 1/200", jf3, ja3);
        end
      end
      next_cycle();
    end
    compared++;
    if (sc3 !== 32'd4) begin
      mismatched++;
      $display("FAIL b2b_cnt: got %0d required 4", sc3);
    end
  endtask

  task automatic test_priority();
    do_reset();
    rib_hold_i = 1; ex_hold_i = 1;
    #1;
    compared++;
    if (hold2 !== 3'd3) begin
      mismatched++;
      $display("FAIL prio_rib_ex: got %0d required 3", hold2);
    end
    next_cycle();
    ex_hold_i = 0;
    #1;
    compared++;
    if (hold2 !== 3'd1) begin
      mismatched++;
      $display("FAIL prio_rib: got %0d required 1", hold2);
    end
    next_cycle();
    rib_hold_i = 0; clint_hold_i = 1;
    #1;
    compared++;
    if (hold2 !== 3'd3) begin
      mismatched++;
      $display("FAIL prio_clint: got %0d required 3", hold2);
    end
    next_cycle();
    clint_hold_i = 0;
    #1;
    compared++;
    if (hold2 !== 3'd0) begin
      mismatched++;
      $display("FAIL prio_none: got %0d required 0", hold2);
    end
  endtask

  task automatic test_debug_halt();
    // Per cycle: jtag, jump, ex_hold, expected hold, expected halted.
    logic [6:0] vec [9] = '{
      {1'b1, 1'b0, 1'b0, 3'd0, 1'b0},  // c0: request sampled, still RUN
      {1'b1, 1'b0, 1'b0, 3'd1, 1'b1},  // c1: halted
      {1'b1, 1'b0, 1'b1, 3'd3, 1'b1},  // c2: ex_hold raises to Hold_Id, stays HALT
      {1'b1, 1'b1, 1'b0, 3'd3, 1'b1},  // c3: jump while halted
      {1'b1, 1'b0, 1'b0, 3'd3, 1'b0},  // c4: FLUSH ignores jtag
      {1'b1, 1'b0, 1'b0, 3'd0, 1'b0},  // c5: RUN, halt taken this edge
      {1'b1, 1'b0, 1'b0, 3'd1, 1'b1},  // c6: HALT re-entered
      {1'b0, 1'b0, 1'b0, 3'd1, 1'b1},  // c7: release sampled
      {1'b0, 1'b0, 1'b0, 3'd0, 1'b0}   // c8: RUN
    };
    do_reset();
    for (int c = 0; c < 9; c++) begin
      jtag_halt_i = vec[c][6]; jump_flag_i = vec[c][5]; ex_hold_i = vec[c][4];
      jump_addr_i = vec[c][5] ? 32'h0000_0400 : 32'h0;
      #1;
      compared++;
      if (hold2 !== vec[c][3:1] || hl2 !== vec[c][0]) begin
        mismatched++;
        $display("FAIL halt_c%0d: hold=%0d halted=%0b required %0d/%0b",
                 c, hold2, hl2, vec[c][3:1], vec[c][0]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_saturation_reset();
    do_reset();
    ex_hold_i = 1;
    for (int c = 0; c < 20; c++) next_cycle();
    ex_hold_i = 0;
    #1;
    compared++;
    if (scs !== 4'd15 || sc2 !== 32'd20) begin
      mismatched++;
      $display("FAIL sat_cnt: narrow=%0d wide=%0d required 15/20", scs, sc2);
    end
    jump_flag_i = 1; jump_addr_i = 32'h0000_0800;
    next_cycle();
    jump_flag_i = 0;
    #1;
    compared++;
    if (holds !== 3'd3) begin
      mismatched++;
      $display("FAIL sat_in_flush: hold=%0d required 3", holds);
    end
    jump_flag_i = 1; rst = 0;
    #1;
    compared++;
    if ({holds, jfs, jas, hls, scs} !== 41'd0) begin
      mismatched++;
      $display("FAIL mid_reset: hold=%0d jf=%0b ja=%h halted=%0b cnt=%0d required all 0",
               holds, jfs, jas, hls, scs);
    end
    clear_inputs();
    next_cycle();
    rst = 1;
    #1;
    compared++;
    if (holds !== 3'd0 || scs !== 4'd0) begin
      mismatched++;
      $display("FAIL post_reset: hold=%0d cnt=%0d required 0/0", holds, scs);
    end
  endtask

  initial begin
    test_reset();
    test_jump_flush();
    test_back_to_back();
    test_priority();
    test_debug_halt();
    test_saturation_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Produces the pipeline hold/flush command consumed by the pc_reg, if_id and id_ex stage registers, plus the redirect (jump) to pc_reg.
- Merges redirect and stall sources: EX jump, EX multi-cycle busy, CLINT, RIB bus, JTAG halt.
- Adds a multi-cycle flush sequencer, a debug-halt state and a saturating stall-cycle counter used for SQED/perf observation.

Parameters:
- FLUSH_CYCLES, 2, cycles Hold_Id is asserted per redirect, including the jump cycle; legal range 1..15.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (`RstEnable` = 0).
- jump_flag_i  in  1  EX requests redirect.
- jump_addr_i  in  32  redirect target.
- ex_hold_i  in  1  EX multi-cycle operation busy (div).
- clint_hold_i  in  1  CLINT interrupt entry/exit in progress.
- rib_hold_i  in  1  RIB bus grant lost; freeze PC.
- jtag_halt_i  in  1  debug halt request (level).
- hold_flag_o  out  3  `Hold_Flag_Bus`: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3.
- jump_flag_o  out  1  redirect to pc_reg.
- jump_addr_o  out  32  redirect target to pc_reg.
- halted_o  out  1  core is in debug halt.
- stall_cnt_o  out  CNT_W  cycles with hold_flag_o != Hold_None, saturating.

Behaviour:
- State: FSM {RUN, FLUSH, HALT}, 4-bit flush_cnt, stall counter. All state registers reset asynchronously on rst=0 to RUN / 0 / 0.
- While rst=0, all outputs are forced to 0: hold_flag_o=Hold_None, jump_flag_o=0, jump_addr_o=0, halted_o=0, stall_cnt_o=0.
- Output logic:
  - jump_flag_o, jump_addr_o and hold_flag_o are combinational from the current state and inputs (zero latency).
  - A redirect must squash if_id/id_ex in the same cycle.
  - jump_addr_o = jump_addr_i when jump_flag_o=1, else 0.
- hold_flag_o priority, highest first:
  - state==FLUSH, or jump_flag_i, or ex_hold_i, or clint_hold_i → Hold_Id.
  - rib_hold_i, or state==HALT → Hold_Pc.
  - otherwise → Hold_None.
- jump_flag_o = jump_flag_i in every state. A redirect is never dropped.
- RUN:
  - jump_flag_i=1 and FLUSH_CYCLES>1 → next FLUSH, flush_cnt <= FLUSH_CYCLES-1.
  - jump_flag_i=1 and FLUSH_CYCLES=1 → stay RUN.
  - else jtag_halt_i=1 → next HALT.
  - else stay RUN.
- FLUSH:
  - hold_flag_o = Hold_Id unconditionally.
  - jump_flag_i=1 → flush_cnt reloads to FLUSH_CYCLES-1, stay FLUSH (latest redirect wins).
  - else flush_cnt==1 → next RUN.
  - else flush_cnt decrements.
  - jtag_halt_i is ignored in FLUSH and taken on the first RUN cycle if still high.
- HALT:
  - halted_o=1, registered state, so it rises one cycle after the jtag_halt_i sample.
  - jump_flag_i=1 → honoured as in RUN (→FLUSH, or stay RUN if FLUSH_CYCLES=1).
  - else jtag_halt_i=0 → next RUN.
  - ex_hold_i or clint_hold_i raises hold_flag_o to Hold_Id, but the state stays HALT.
- stall_cnt_o:
  - On each rising edge where hold_flag_o != Hold_None, increments by 1.
  - Holds at all-ones (no wrap).
- Reset mid-operation: FLUSH or HALT is abandoned immediately. After release, state is RUN with flush_cnt=0.

Test Plan:
- Reset: rst=0 with all inputs toggling → every output 0. Release rst with inputs 0 → hold_flag_o=0, stall_cnt_o=0.
- Jump flush: FLUSH_CYCLES=2, one-cycle jump_flag_i=1, jump_addr_i=0x0000_0100:
  - Cycle 0: hold_flag_o=3, jump_flag_o=1, jump_addr_o=0x100.
  - Cycle 1: hold_flag_o=3, jump_flag_o=0.
  - Cycle 2: hold_flag_o=0.
  - stall_cnt_o=2.
- Back-to-back redirect: jumps at cycle 0 (target 0x100) and cycle 1 (target 0x200), FLUSH_CYCLES=3:
  - Hold_Id for cycles 0..3.
  - jump_addr_o=0x200 at cycle 1.
  - RUN at cycle 4.
- Priority: rib_hold_i=1 and ex_hold_i=1 together → 3. Drop ex_hold_i → 1. Drop rib_hold_i → 0.
- Debug halt:
  - jtag_halt_i=1 at cycle 0 → hold_flag_o=1 from cycle 1, halted_o=1 from cycle 1.
  - Jump at cycle 3 while halted → hold_flag_o=3 and state leaves HALT.
  - jtag_halt_i still 1 after the flush → HALT re-entered.
- Saturation and reset: CNT_W=4, ex_hold_i=1 for 20 cycles → stall_cnt_o=15. Assert rst during FLUSH → state RUN, counter 0.
